// File: rtl/eps_rr_scheduler.sv
// Round-robin scheduler that shares one angle->eps converter among NREQ argmax channels.
// Each channel owns a 1-deep angle slot; results return downstream tagged with the channel id.
module eps_rr_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned ANG_W = 13,
  parameter int unsigned EPS_W = 21,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*ANG_W-1:0]   i_req_ang,
  output logic [NREQ-1:0]         o_req_ready,
  output logic [ANG_W-1:0]        o_sel_ang,
  output logic                    o_sel_valid,
  input  logic [EPS_W-1:0]        i_sel_eps,
  input  logic                    i_sel_eps_valid,
  output logic                    o_eps_valid,
  output logic [EPS_W-1:0]        o_eps_data,
  output logic [ID_W-1:0]         o_eps_id,
  input  logic                    i_eps_ready,
  output logic                    o_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StOut} state_e;

  state_e             r_state;
  state_e             w_state_d;

  logic [NREQ-1:0]    r_hold_full;
  logic [ANG_W-1:0]   r_hold_ang [NREQ];
  logic [NREQ-1:0]    w_take;
  logic [NREQ-1:0]    w_clear;

  logic [ANG_W-1:0]   r_issue_ang;
  logic [ID_W-1:0]    r_issue_id;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [EPS_W-1:0]   r_eps_data;
  logic [ID_W-1:0]    r_eps_id;

  logic               w_grant_found;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W:0]      w_cand_sum;
  logic [ID_W-1:0]    w_cand;
  logic               w_capture;

  // ---------------------------------------------------------------------------
  // Holding slots
  // ---------------------------------------------------------------------------
  assign o_req_ready = ~r_hold_full & {NREQ{~i_rst}};
  assign w_take      = i_req_valid & o_req_ready;

  always_comb begin
    w_clear = '0;
    if (w_capture) begin
      w_clear[r_issue_id] = 1'b1;
    end
  end

  // Angle storage carries no reset: it is only ever read behind hold_full.
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_take[i]) begin
        r_hold_ang[i] <= i_req_ang[i*ANG_W +: ANG_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first full slot after the last served channel
  // ---------------------------------------------------------------------------
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = r_rr_ptr;
    w_cand_sum    = '0;
    w_cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_cand_sum >= (ID_W+1)'(NREQ)) begin
        w_cand_sum = w_cand_sum - (ID_W+1)'(NREQ);
      end
      w_cand = w_cand_sum[ID_W-1:0];
      if (!w_grant_found && r_hold_full[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant_found) begin
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (i_sel_eps_valid) begin
          w_capture = 1'b1;
          w_state_d = StOut;
        end
      end
      StOut: begin
        if (i_eps_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_full <= '0;
      r_rr_ptr    <= ID_W'(NREQ - 1);
      r_issue_ang <= '0;
      r_issue_id  <= '0;
      r_eps_data  <= '0;
      r_eps_id    <= '0;
    end else begin
      // A slot being cleared has req_ready low, so set and clear never collide.
      r_hold_full <= (r_hold_full & ~w_clear) | w_take;
      if (r_state == StIdle && w_grant_found) begin
        r_issue_ang <= r_hold_ang[w_grant_id];
        r_issue_id  <= w_grant_id;
      end
      if (w_capture) begin
        r_eps_data <= i_sel_eps;
        r_eps_id   <= r_issue_id;
        r_rr_ptr   <= r_issue_id;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, forced idle while reset is asserted
  // ---------------------------------------------------------------------------
  assign o_sel_valid = (r_state == StIssue) & ~i_rst;
  assign o_sel_ang   = o_sel_valid ? r_issue_ang : '0;
  assign o_eps_valid = (r_state == StOut) & ~i_rst;
  assign o_eps_data  = r_eps_data;
  assign o_eps_id    = r_eps_id;
  assign o_busy      = ((r_state != StIdle) | (|r_hold_full)) & ~i_rst;

endmodule

// File: tb/tb_eps_rr_scheduler.sv
// Bench for eps_rr_scheduler: behavioural slot/job model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_eps_rr_scheduler;
  localparam int NREQ  = 4;
  localparam int ANG_W = 13;
  localparam int EPS_W = 21;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*ANG_W-1:0] req_ang;
  logic [NREQ-1:0]   req_ready;
  logic [ANG_W-1:0]  sel_ang;
  logic              sel_valid;
  logic [EPS_W-1:0]  sel_eps;
  logic              sel_eps_valid;
  logic              eps_valid;
  logic [EPS_W-1:0]  eps_data;
  logic [1:0]        eps_id;
  logic              eps_ready;
  logic              busy;

  always #5 clk = ~clk;

  eps_rr_scheduler #(.NREQ(NREQ), .ANG_W(ANG_W), .EPS_W(EPS_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_ang      (req_ang),
    .o_req_ready    (req_ready),
    .o_sel_ang      (sel_ang),
    .o_sel_valid    (sel_valid),
    .i_sel_eps      (sel_eps),
    .i_sel_eps_valid(sel_eps_valid),
    .o_eps_valid    (eps_valid),
    .o_eps_data     (eps_data),
    .o_eps_id       (eps_id),
    .i_eps_ready    (eps_ready),
    .o_busy         (busy)
  );

  // Combinational stand-in for the converter: eps = floor(ang*1311 / 8)
  logic signed [33:0] conv_prod;
  logic signed [33:0] conv_sh;
  assign conv_prod     = $signed(sel_ang) * 34'sd1311;
  assign conv_sh       = conv_prod >>> 3;
  assign sel_eps       = conv_sh[EPS_W-1:0];
  assign sel_eps_valid = sel_valid;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [EPS_W-1:0] ref_eps(input logic [ANG_W-1:0] a);
    int p;
    p = $signed(a) * 1311;
    return EPS_W'(p >>> 3);
  endfunction

  // Model: slot occupancy plus at most one job in flight, tracked by age since grant
  bit               m_init = 1'b0;
  bit               m_full [NREQ];
  logic [ANG_W-1:0] m_ang  [NREQ];
  int               m_ptr;
  bit               m_active;
  int               m_id;
  int               m_age;
  logic [EPS_W-1:0] m_res;
  int               m_res_id;
  int               cyc = 0;

  int               dq_id[$];
  logic [EPS_W-1:0] dq_data[$];
  int               dq_cyc[$];

  always @(posedge clk) begin : model
    bit acc [NREQ];
    bit found;
    int c;
    cyc++;
    if (rst) begin
      m_init = 1'b1;
      for (int i = 0; i < NREQ; i++) m_full[i] = 1'b0;
      m_ptr = NREQ - 1;
      m_active = 1'b0;
      m_res = '0;
      m_res_id = 0;
    end else if (m_init) begin
      for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] && !m_full[i];
      if (!m_active) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (!found && m_full[c]) begin
            found = 1'b1;
            m_active = 1'b1;
            m_id = c;
            m_age = 1;
          end
        end
      end else if (m_age == 1) begin
        m_res = ref_eps(m_ang[m_id]);
        m_res_id = m_id;
        m_full[m_id] = 1'b0;
        m_ptr = m_id;
        m_age = 2;
      end else if (eps_ready) begin
        m_active = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          m_full[i] = 1'b1;
          m_ang[i] = req_ang[i*ANG_W +: ANG_W];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] exp_ready;
    bit any_full;
    bit issuing;
    bit presenting;
    if (m_init) begin
      exp_ready = '0;
      any_full = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        exp_ready[i] = !m_full[i] && !rst;
        any_full |= m_full[i];
      end
      issuing    = m_active && m_age == 1 && !rst;
      presenting = m_active && m_age == 2 && !rst;
      chk("req_ready", req_ready, exp_ready);
      chk("sel_valid", sel_valid, issuing);
      chk("sel_ang", sel_ang, issuing ? m_ang[m_id] : '0);
      chk("eps_valid", eps_valid, presenting);
      chk("busy", busy, (m_active || any_full) && !rst);
      if (!rst) begin
        chk("eps_data", eps_data, m_res);
        chk("eps_id", eps_id, m_res_id);
      end
      if (!rst && eps_valid && eps_ready) begin
        dq_id.push_back(int'(eps_id));
        dq_data.push_back(eps_data);
        dq_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ang(input int ch, input logic [ANG_W-1:0] a);
    req_ang[ch*ANG_W +: ANG_W] = a;
  endtask

  task automatic clear_log();
    dq_id.delete();
    dq_data.delete();
    dq_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Counts negedges until eps_valid; 0 means it never arrived within bound
  task automatic wait_eps(output int n, input int bound);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (eps_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("eps_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int pos3;
    rst = 1'b1;
    req_valid = '0;
    req_ang = '0;
    eps_ready = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel_valid", sel_valid, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 4'hF);
    chk("post_rst_eps_valid", eps_valid, 1'b0);
    chk("post_rst_eps_data", eps_data, 21'h0);
    chk("post_rst_eps_id", eps_id, 2'd0);

    // 1. Single request on ch2
    tick();
    req_valid[2] = 1'b1;
    set_ang(2, 13'h192);
    tick();
    req_valid = '0;
    wait_eps(n, 10);
    chk("t1_latency", n, 3);
    chk("t1_eps_data", eps_data, 21'h10155);
    chk("t1_eps_id", eps_id, 2'd2);
    repeat (3) tick();

    // 2. Negative angle on ch1
    req_valid[1] = 1'b1;
    set_ang(1, 13'h1E6E);
    tick();
    req_valid = '0;
    wait_eps(n, 10);
    chk("t2_latency", n, 3);
    chk("t2_eps_data", eps_data, 21'h1EFEAA);
    chk("t2_eps_id", eps_id, 2'd1);
    repeat (3) tick();

    // 3. All channels at once from a fresh pointer
    do_reset();
    clear_log();
    req_valid = 4'hF;
    set_ang(0, 13'd100);
    set_ang(1, 13'd200);
    set_ang(2, 13'h1ED4);
    set_ang(3, 13'd500);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t3_ready_low", req_ready, 4'h0);
    repeat (15) tick();
    chk("t3_count", dq_id.size(), 4);
    for (int i = 0; i < dq_id.size() && i < 4; i++) begin
      chk("t3_order", dq_id[i], i);
      if (i > 0) chk("t3_spacing", dq_cyc[i] - dq_cyc[i-1], 3);
    end
    if (dq_data.size() > 0) chk("t3_first_data", dq_data[0], 21'h4003);

    // 4. Backpressure with a refill during OUT
    eps_ready = 1'b0;
    req_valid = 4'b0101;
    set_ang(0, 13'd1000);
    set_ang(2, 13'h1FFF);
    tick();
    req_valid = '0;
    wait_eps(n, 10);
    chk("t4_first_id", eps_id, 2'd0);
    chk("t4_first_data", eps_data, 21'h28023);
    tick();
    req_valid[0] = 1'b1;
    set_ang(0, 13'd5);
    tick();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", eps_valid, 1'b1);
      chk("t4_hold_id", eps_id, 2'd0);
      chk("t4_hold_data", eps_data, 21'h28023);
      chk("t4_hold_ready", req_ready, 4'b1010);
      tick();
    end
    clear_log();
    eps_ready = 1'b1;
    repeat (12) tick();
    chk("t4_count", dq_id.size(), 3);
    if (dq_id.size() == 3) begin
      chk("t4_id0", dq_id[0], 0);
      chk("t4_id1", dq_id[1], 2);
      chk("t4_id2", dq_id[2], 0);
      chk("t4_data0", dq_data[0], 21'h28023);
      chk("t4_data1", dq_data[1], 21'h1FFF5C);
      chk("t4_data2", dq_data[2], 21'h333);
    end

    // 5. Fairness: ch0/ch1 hammer, ch3 requests once
    do_reset();
    clear_log();
    req_valid = 4'b1011;
    set_ang(0, 13'd7);
    set_ang(1, 13'd8);
    set_ang(3, 13'd9);
    tick();
    req_valid[3] = 1'b0;
    repeat (30) tick();
    req_valid = '0;
    repeat (10) tick();
    pos3 = -1;
    foreach (dq_id[i]) if (dq_id[i] == 3 && pos3 < 0) pos3 = i;
    chk("t5_ch3_pos", pos3, 2);
    chk("t5_enough", dq_id.size() >= 5, 1'b1);
    if (dq_id.size() >= 5) begin
      chk("t5_seq0", dq_id[0], 0);
      chk("t5_seq1", dq_id[1], 1);
      chk("t5_seq3", dq_id[3], 0);
      chk("t5_seq4", dq_id[4], 1);
    end

    // 6. Reset while a result is held
    eps_ready = 1'b0;
    req_valid = 4'b0110;
    set_ang(1, 13'd50);
    set_ang(2, 13'd60);
    tick();
    req_valid = '0;
    wait_eps(n, 10);
    chk("t6_in_out", eps_id, 2'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_eps_valid", eps_valid, 1'b0);
    chk("t6_rst_ready", req_ready, 4'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_eps_valid", eps_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", req_ready, 4'hF);
    clear_log();
    eps_ready = 1'b1;
    repeat (8) tick();
    chk("t6_no_stale", dq_id.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
